// File: rtl/debounce_sync_pkg.sv
// State encodings shared by the debounce FSM and any reuse of it.
// Pure type/helper package; no logic, no latency, no flow control.
package debounce_sync_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_CHECK_HI  = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_CHECK_LO  = 2'd3
  } state_e;

  function automatic logic is_check(input state_e s);
    return (s == ST_CHECK_HI) || (s == ST_CHECK_LO);
  endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// Plain N-flop metastability synchronizer, cleared to 0 by async reset.
// Latency SYNC_STAGES edges; free-running, no enable and no backpressure.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic REST,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_in};
  end

  always_ff @(posedge clk or negedge REST) begin
    if (!REST) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a bouncy input into a clean level plus edge pulses.
// d_out moves SYNC_STAGES+DEBOUNCE_CYCLES edges after a raw change; en only gates qualification.
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic REST,
  input  logic raw_in,
  input  logic en,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_out_q, d_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .REST     (REST),
    .async_in (raw_in),
    .sync_out (sync_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE_LO: begin
        if (en && sync_q) begin
          state_d = ST_CHECK_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CHECK_HI: begin
        if (en) begin
          if (!sync_q) begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE_HI;
            cnt_d   = '0;
            d_out_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_STABLE_HI: begin
        if (en && !sync_q) begin
          state_d = ST_CHECK_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_CHECK_LO: begin
        if (en) begin
          if (sync_q) begin
            state_d = ST_STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
            d_out_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // Corrupted state register: fall back to a known idle level without waiting for en.
      default: begin
        state_d = ST_STABLE_LO;
        cnt_d   = '0;
        d_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge REST) begin
    if (!REST) begin
      state_q <= ST_STABLE_LO;
      cnt_q   <= '0;
      d_out_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign d_out      = d_out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = is_check(state_q);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed and random stimulus for debounce_sync, checked against a run-length reference model.
module tb_debounce_sync;

  localparam int SS = 2;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic REST;
  logic raw_in;
  logic en;
  logic d_out, rise_pulse, fall_pulse, busy;

  int errors = 0;
  int checks = 0;

  // Reference model: raw history queue gives the synchronized value; lvl/run hold the
  // accepted level and the number of consecutive enabled samples disagreeing with it.
  logic hist[$];
  logic m_lvl, m_rise, m_fall, m_sync;
  int   m_run;

  debounce_sync #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .REST       (REST),
    .raw_in     (raw_in),
    .en         (en),
    .d_out      (d_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_lvl  = 1'b0;
    m_run  = 0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_sync = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic e);
    m_sync = (hist.size() >= SS) ? hist[hist.size() - SS] : 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (e) begin
      if (m_sync != m_lvl) begin
        m_run++;
        if (m_run == DC) begin
          m_lvl  = m_sync;
          m_run  = 0;
          m_rise = m_lvl;
          m_fall = !m_lvl;
        end
      end else begin
        m_run = 0;
      end
    end
    hist.push_back(r);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".d_out"}, int'(d_out), int'(m_lvl));
    check({tag, ".rise"},  int'(rise_pulse), int'(m_rise));
    check({tag, ".fall"},  int'(fall_pulse), int'(m_fall));
    check({tag, ".busy"},  int'(busy), int'(m_run != 0));
  endtask

  task automatic step(input logic r, input logic e, input string tag);
    raw_in = r;
    en     = e;
    @(posedge clk);
    if (REST) model_edge(r, e);
    else      model_reset();
    #1;
    compare_all(tag);
  endtask

  initial begin
    int first;
    int hits;
    int rises;
    logic r;

    REST   = 1'b0;
    raw_in = 1'b1;
    en     = 1'b1;
    model_reset();
    #1;
    compare_all("reset0");

    // 1: held in reset with raw_in high, then release
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, "in_reset");
    REST  = 1'b1;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, "rel_rise");
      if (rise_pulse && first == 0) first = k;
    end
    check("rel_rise_edge", first, 6);

    // 4: clean fall from STABLE_HI
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, "fall");
      if (!d_out && first == 0) first = k;
    end
    check("fall_edge", first, 6);

    // 2: clean rise, busy window and pulse width
    first = 0;
    rises = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, "rise");
      if (d_out && first == 0) first = k;
      if (rise_pulse) rises++;
      if (k >= 3 && k <= 5) check("rise_busy", int'(busy), 1);
      check("rise_no_fall", int'(fall_pulse), 0);
    end
    check("rise_edge", first, 6);
    check("rise_pulse_cycles", rises, 1);

    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, "to_lo");

    // 3: glitch rejected at the terminal sample
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, "glitch_hi");
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, "glitch_lo");
    check("glitch_d_out", int'(d_out), 0);
    check("glitch_busy", int'(busy), 0);

    // 5: en on every third edge
    hits  = 0;
    first = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b1, (k % 3) == 2, "en_gate");
      if (en && m_sync) hits++;
      if (d_out && first == 0) first = hits;
    end
    check("en_gate_hits", first, 4);

    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, "to_lo2");

    // 6: async reset in the middle of a rise
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, "mid_rise");
    check("mid_busy", int'(busy), 1);
    #2;
    REST = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    step(1'b0, 1'b1, "rst_hold");
    REST  = 1'b1;
    rises = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, "after_rst");
      if (rise_pulse) rises++;
    end
    check("after_rst_rises", rises, 0);

    // Random bouncing with random enable
    r = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) r = ~r;
      step(r, $urandom_range(0, 3) != 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
